// File: rtl/decode_stage.sv
// RV32I decode stage: combinational decode into a 2-entry skid-buffered, registered output.
// Optional macro DECODE_ILLEGAL_HALT_EN stalls intake once an illegal entry reaches the output register.
module decode_stage #(
  parameter int unsigned PC_W = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [PC_W-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [PC_W-1:0] out_pc,
  output logic [2:0]      alu_select,
  output logic [7:0]      alu_operation,
  output logic [31:0]     imm_value,
  output logic [4:0]      rs1_addr,
  output logic [4:0]      rs2_addr,
  output logic [4:0]      rd_addr,
  output logic            rd_we,
  output logic            illegal
);

  localparam logic [2:0] SEL_NOP        = 3'd0;
  localparam logic [2:0] SEL_ARITHMETIC = 3'd1;
  localparam logic [2:0] SEL_LOAD       = 3'd2;

  localparam logic [7:0] OP_NOP   = 8'd0;
  localparam logic [7:0] OP_ADD   = 8'd1;
  localparam logic [7:0] OP_SUB   = 8'd2;
  localparam logic [7:0] OP_SLL   = 8'd3;
  localparam logic [7:0] OP_SLT   = 8'd4;
  localparam logic [7:0] OP_SLTU  = 8'd5;
  localparam logic [7:0] OP_XOR   = 8'd6;
  localparam logic [7:0] OP_SRL   = 8'd7;
  localparam logic [7:0] OP_SRA   = 8'd8;
  localparam logic [7:0] OP_OR    = 8'd9;
  localparam logic [7:0] OP_AND   = 8'd10;
  localparam logic [7:0] OP_ADDI  = 8'd11;
  localparam logic [7:0] OP_SLTI  = 8'd12;
  localparam logic [7:0] OP_SLTIU = 8'd13;
  localparam logic [7:0] OP_XORI  = 8'd14;
  localparam logic [7:0] OP_ORI   = 8'd15;
  localparam logic [7:0] OP_ANDI  = 8'd16;
  localparam logic [7:0] OP_SLLI  = 8'd17;
  localparam logic [7:0] OP_SRLI  = 8'd18;
  localparam logic [7:0] OP_SRAI  = 8'd19;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [2:0]      sel;
    logic [7:0]      op;
    logic [31:0]     imm;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic            we;
    logic            ill;
  } entry_t;

  typedef enum logic [1:0] {
    S_EMPTY,
    S_ONE,
    S_FULL
  } state_e;

  state_e state_q, state_d;
  entry_t out_q, out_d;
  entry_t skid_q, skid_d;
  entry_t dec;

  logic [6:0] opcode;
  logic [6:0] funct7;
  logic [2:0] funct3;
  logic       legal;
  logic       accept;
  logic       consume;

  always_comb begin
    opcode  = in_instr[6:0];
    funct3  = in_instr[14:12];
    funct7  = in_instr[31:25];
    legal   = 1'b0;
    dec     = '0;
    dec.pc  = in_pc;
    dec.rs1 = in_instr[19:15];
    dec.rs2 = in_instr[24:20];
    dec.rd  = in_instr[11:7];
    case (opcode)
      OPC_OP: begin
        dec.sel = SEL_ARITHMETIC;
        if (funct7 == 7'b0000000) begin
          legal = 1'b1;
          case (funct3)
            3'b000:  dec.op = OP_ADD;
            3'b001:  dec.op = OP_SLL;
            3'b010:  dec.op = OP_SLT;
            3'b011:  dec.op = OP_SLTU;
            3'b100:  dec.op = OP_XOR;
            3'b101:  dec.op = OP_SRL;
            3'b110:  dec.op = OP_OR;
            default: dec.op = OP_AND;
          endcase
        end else if (funct7 == 7'b0100000) begin
          if (funct3 == 3'b000) begin
            legal  = 1'b1;
            dec.op = OP_SUB;
          end else if (funct3 == 3'b101) begin
            legal  = 1'b1;
            dec.op = OP_SRA;
          end
        end
      end
      OPC_OP_IMM: begin
        dec.sel = SEL_ARITHMETIC;
        dec.imm = {{20{in_instr[31]}}, in_instr[31:20]};
        legal   = 1'b1;
        case (funct3)
          3'b000: dec.op = OP_ADDI;
          3'b010: dec.op = OP_SLTI;
          3'b011: dec.op = OP_SLTIU;
          3'b100: dec.op = OP_XORI;
          3'b110: dec.op = OP_ORI;
          3'b001: begin
            dec.op  = OP_SLLI;
            dec.imm = {27'b0, in_instr[24:20]};
            legal   = (funct7 == 7'b0000000);
          end
          3'b101: begin
            dec.imm = {27'b0, in_instr[24:20]};
            if (funct7 == 7'b0000000) begin
              dec.op = OP_SRLI;
            end else if (funct7 == 7'b0100000) begin
              dec.op = OP_SRAI;
            end else begin
              legal = 1'b0;
            end
          end
          default: dec.op = OP_ANDI;
        endcase
      end
      OPC_LOAD: begin
        dec.sel = SEL_LOAD;
        dec.op  = OP_NOP;
        dec.imm = {{20{in_instr[31]}}, in_instr[31:20]};
        legal   = 1'b1;
      end
      default: legal = 1'b0;
    endcase
    // Register indices stay visible on illegal entries; everything else collapses to NOP.
    if (legal) begin
      dec.we = (dec.rd != 5'd0);
    end else begin
      dec.sel = SEL_NOP;
      dec.op  = OP_NOP;
      dec.imm = '0;
      dec.we  = 1'b0;
      dec.ill = 1'b1;
    end
  end

  assign accept  = in_valid & in_ready & ~flush;
  assign consume = out_valid & out_ready;

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = S_EMPTY;
    end else begin
      case (state_q)
        S_EMPTY: begin
          if (accept) begin
            out_d   = dec;
            state_d = S_ONE;
          end
        end
        S_ONE: begin
          if (accept && consume) begin
            out_d = dec;
          end else if (accept) begin
            skid_d  = dec;
            state_d = S_FULL;
          end else if (consume) begin
            state_d = S_EMPTY;
          end
        end
        S_FULL: begin
          if (consume) begin
            out_d   = skid_q;
            state_d = S_ONE;
          end
        end
        default: state_d = S_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_EMPTY;
      out_q   <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      skid_q  <= skid_d;
    end
  end

`ifdef DECODE_ILLEGAL_HALT_EN
  logic halt_q, halt_d;

  // Halt latches as soon as the output register will hold a valid illegal entry.
  always_comb begin
    halt_d = ~flush & (halt_q | ((state_d != S_EMPTY) & out_d.ill));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      halt_q <= 1'b0;
    end else begin
      halt_q <= halt_d;
    end
  end

  assign in_ready = (state_q != S_FULL) & ~halt_q;
`else
  assign in_ready = (state_q != S_FULL);
`endif

  assign out_valid     = (state_q != S_EMPTY);
  assign out_pc        = out_q.pc;
  assign alu_select    = out_q.sel;
  assign alu_operation = out_q.op;
  assign imm_value     = out_q.imm;
  assign rs1_addr      = out_q.rs1;
  assign rs2_addr      = out_q.rs2;
  assign rd_addr       = out_q.rd;
  assign rd_we         = out_q.we;
  assign illegal       = out_q.ill;

endmodule
